// File: rtl/proc_sys_reset_requester.sv
// Initiator side of the proc_sys_reset handshake: drives a timed aux reset pulse, then
// confirms interconnect/peripheral resets fall and recover, reporting busy/done/err status.
module proc_sys_reset_requester #(
    parameter int unsigned C_PULSE_CYC      = 16,
    parameter int unsigned C_TIMEOUT_CYC    = 1024,
    parameter int unsigned C_STABLE_CYC     = 4,
    parameter int unsigned C_AUX_RESET_HIGH = 1,
    parameter int unsigned C_CNT_W          = 16
) (
    input  logic       slowest_sync_clk,
    input  logic       ext_reset_in,
    input  logic       sw_rst_req,
    input  logic       dcm_locked,
    input  logic       interconnect_aresetn,
    input  logic       peripheral_aresetn,
    output logic       aux_reset_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code,
    output logic [7:0] drop_cnt
);
    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StWaitLow,
        StWaitHigh,
        StDone,
        StErr
    } state_e;

    localparam logic               AuxOn       = (C_AUX_RESET_HIGH != 0);
    localparam logic               AuxOff      = !AuxOn;
    localparam logic [C_CNT_W-1:0] PulseLast   = C_CNT_W'(C_PULSE_CYC - 1);
    localparam logic [C_CNT_W-1:0] TimeoutCnt  = C_CNT_W'(C_TIMEOUT_CYC);
    localparam logic [C_CNT_W-1:0] StableCnt   = C_CNT_W'(C_STABLE_CYC);
    localparam logic [1:0]         CodeAssert  = 2'd1;
    localparam logic [1:0]         CodeRelease = 2'd2;
    localparam logic [1:0]         CodeClock   = 2'd3;

    state_e             state_q, state_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d, stab_q, stab_d, cnt_inc, stab_inc;
    logic               seen_ic_q, seen_ic_d, seen_pr_q, seen_pr_d;
    logic               aux_q, aux_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [1:0]         code_q, code_d, fail_code;
    logic [7:0]         drop_q, drop_d;
    logic               fail, both_high;

    always_comb begin
        // Counters saturate rather than wrap so a stuck wait still times out.
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + C_CNT_W'(1);
        stab_inc  = (stab_q == '1) ? stab_q : stab_q + C_CNT_W'(1);
        both_high = interconnect_aresetn && peripheral_aresetn;

        state_d   = state_q;
        cnt_d     = cnt_inc;
        stab_d    = '0;
        seen_ic_d = seen_ic_q;
        seen_pr_d = seen_pr_q;
        aux_d     = AuxOff;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        code_d    = code_q;
        drop_d    = drop_q;
        fail      = 1'b0;
        fail_code = CodeClock;

        if (sw_rst_req && busy_q && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (sw_rst_req) begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    code_d = 2'd0;
                    if (dcm_locked) begin
                        state_d   = StAssert;
                        aux_d     = AuxOn;
                        seen_ic_d = 1'b0;
                        seen_pr_d = 1'b0;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            StAssert: begin
                seen_ic_d = seen_ic_q || !interconnect_aresetn;
                seen_pr_d = seen_pr_q || !peripheral_aresetn;
                aux_d     = AuxOn;
                if (!dcm_locked) begin
                    fail = 1'b1;
                end else if (cnt_q >= PulseLast) begin
                    state_d = StWaitLow;
                    cnt_d   = '0;
                    aux_d   = AuxOff;
                end
            end
            StWaitLow: begin
                seen_ic_d = seen_ic_q || !interconnect_aresetn;
                seen_pr_d = seen_pr_q || !peripheral_aresetn;
                if (!dcm_locked) begin
                    fail = 1'b1;
                end else if (seen_ic_d && seen_pr_d) begin
                    state_d = StWaitHigh;
                    cnt_d   = '0;
                end else if (cnt_q >= TimeoutCnt) begin
                    fail      = 1'b1;
                    fail_code = CodeAssert;
                end
            end
            StWaitHigh: begin
                if (!dcm_locked) begin
                    fail = 1'b1;
                end else if (stab_q >= StableCnt) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else if (cnt_q >= TimeoutCnt) begin
                    fail      = 1'b1;
                    fail_code = CodeRelease;
                end else begin
                    stab_d = both_high ? stab_inc : '0;
                end
            end
            StDone, StErr: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase

        if (fail) begin
            state_d = StErr;
            err_d   = 1'b1;
            code_d  = fail_code;
            cnt_d   = '0;
            stab_d  = '0;
            aux_d   = AuxOff;
        end
    end

    always_ff @(posedge slowest_sync_clk) begin
        if (ext_reset_in) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            stab_q    <= '0;
            seen_ic_q <= 1'b0;
            seen_pr_q <= 1'b0;
            aux_q     <= AuxOff;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stab_q    <= stab_d;
            seen_ic_q <= seen_ic_d;
            seen_pr_q <= seen_pr_d;
            aux_q     <= aux_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            drop_q    <= drop_d;
        end
    end

    assign aux_reset_out = aux_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_code      = code_q;
    assign drop_cnt      = drop_q;
endmodule
